// File: rtl/operand_fetch_pkg.sv
// Shared constants, FSM state type and operand-resolution helper for the
// operand fetch stage.
package operand_fetch_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OUT
  } fetch_state_t;

  // A same-cycle writeback to the source beats the stale register-file value.
  function automatic logic [DATA_W-1:0] resolve_operand(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  wb_valid,
    input logic [REG_ADDR_W-1:0] wb_rc,
    input logic [DATA_W-1:0]     wb_data,
    input logic [DATA_W-1:0]     rf_data
  );
    if (src == '0)
      return '0;
    else if (wb_valid && (wb_rc == src))
      return wb_data;
    else
      return rf_data;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, with query
// outputs that already account for a writeback clearing the bit this cycle.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rc,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rc,
  input  logic [REG_ADDR_W-1:0] query_a,
  input  logic [REG_ADDR_W-1:0] query_b,
  input  logic [REG_ADDR_W-1:0] query_d,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_d
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Clear first, then set, so a same-edge set on the same register wins.
  always_comb begin
    pending_next = pending;
    if (clr_en && (clr_rc != '0))
      pending_next[clr_rc] = 1'b0;
    if (set_en && (set_rc != '0))
      pending_next[set_rc] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pending <= '0;
    else
      pending <= pending_next;
  end

  assign busy_a = (query_a != '0) && pending[query_a] && !(clr_en && (clr_rc == query_a));
  assign busy_b = (query_b != '0) && pending[query_b] && !(clr_en && (clr_rc == query_b));
  assign busy_d = (query_d != '0) && pending[query_d] && !(clr_en && (clr_rc == query_d));

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: captures one instruction, waits out RAW/WAW hazards
// against the scoreboard, then presents resolved operands downstream.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_ra,
  input  logic [REG_ADDR_W-1:0] in_rb,
  input  logic [REG_ADDR_W-1:0] in_rc,
  input  logic                  in_wr,
  output logic [REG_ADDR_W-1:0] rf_ra,
  output logic [REG_ADDR_W-1:0] rf_rb,
  input  logic [DATA_W-1:0]     rf_rd1,
  input  logic [DATA_W-1:0]     rf_rd2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic [REG_ADDR_W-1:0] out_rc,
  output logic                  out_wr,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rc,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  rf_load_enable,
  output logic [REG_ADDR_W-1:0] rf_rc,
  output logic [DATA_W-1:0]     rf_ry
);

  fetch_state_t          state;
  logic [REG_ADDR_W-1:0] held_ra;
  logic [REG_ADDR_W-1:0] held_rb;
  logic [REG_ADDR_W-1:0] held_rc;
  logic                  held_wr;
  logic                  busy_a;
  logic                  busy_b;
  logic                  busy_d;
  logic                  hazard;
  logic                  issue;
  logic [DATA_W-1:0]     operand_a;
  logic [DATA_W-1:0]     operand_b;

  assign hazard    = busy_a || busy_b || (held_wr && busy_d);
  assign issue     = (state == HOLD) && !hazard;
  assign operand_a = resolve_operand(held_ra, wb_valid, wb_rc, wb_data, rf_rd1);
  assign operand_b = resolve_operand(held_rb, wb_valid, wb_rc, wb_data, rf_rd2);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign rf_ra     = (state == HOLD) ? held_ra : '0;
  assign rf_rb     = (state == HOLD) ? held_rb : '0;

  // Writeback is forwarded to the register file regardless of FSM state or reset.
  assign rf_load_enable = wb_valid;
  assign rf_rc          = wb_rc;
  assign rf_ry          = wb_data;

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (issue && held_wr),
    .set_rc  (held_rc),
    .clr_en  (wb_valid),
    .clr_rc  (wb_rc),
    .query_a (held_ra),
    .query_b (held_rb),
    .query_d (held_rc),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .busy_d  (busy_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      held_ra <= '0;
      held_rb <= '0;
      held_rc <= '0;
      held_wr <= 1'b0;
      out_a   <= '0;
      out_b   <= '0;
      out_rc  <= '0;
      out_wr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            held_ra <= in_ra;
            held_rb <= in_rb;
            held_rc <= in_rc;
            held_wr <= in_wr;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (!hazard) begin
            out_a  <= operand_a;
            out_b  <= operand_b;
            out_rc <= held_rc;
            out_wr <= held_wr;
            state  <= OUT;
          end
        end
        OUT: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_ra, in_rb, in_rc;
  logic        in_wr;
  logic [4:0]  rf_ra, rf_rb;
  logic [31:0] rf_rd1, rf_rd2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_rc;
  logic        out_wr;
  logic        wb_valid;
  logic [4:0]  wb_rc;
  logic [31:0] wb_data;
  logic        rf_load_enable;
  logic [4:0]  rf_rc;
  logic [31:0] rf_ry;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] rf_mem [32];

  // Model of the in-flight instruction and pending-write set
  bit          m_held, m_present;
  logic [4:0]  m_ra, m_rb, m_rc;
  bit          m_wr;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_orc;
  bit          m_owr;
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_wr(in_wr),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rc(out_rc), .out_wr(out_wr),
    .wb_valid(wb_valid), .wb_rc(wb_rc), .wb_data(wb_data),
    .rf_load_enable(rf_load_enable), .rf_rc(rf_rc), .rf_ry(rf_ry)
  );

  assign rf_rd1 = rf_mem[rf_ra];
  assign rf_rd2 = rf_mem[rf_rb];

  always @(posedge clk)
    if (wb_valid && wb_rc != 5'd0) rf_mem[wb_rc] <= wb_data;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit pendLive(input logic [4:0] s);
    return (s != 5'd0) && m_pend[s] && !(wb_valid && wb_rc == s);
  endfunction

  function automatic logic [31:0] modelOperand(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    if (wb_valid && wb_rc == s) return wb_data;
    return rf_mem[s];
  endfunction

  // Compare against the model, then advance the model using this cycle's inputs
  always @(negedge clk) begin : compare
    logic [31:0] np;
    bit stall;
    if (chk_en) begin
      checkOutput("in_ready", in_ready, (!m_held && !m_present));
      checkOutput("out_valid", out_valid, m_present);
      checkOutput("rf_ra", rf_ra, m_held ? m_ra : 5'd0);
      checkOutput("rf_rb", rf_rb, m_held ? m_rb : 5'd0);
      if (m_present) begin
        checkOutput("out_a", out_a, m_a);
        checkOutput("out_b", out_b, m_b);
        checkOutput("out_rc", out_rc, m_orc);
        checkOutput("out_wr", out_wr, m_owr);
      end
      checkOutput("rf_load_enable", rf_load_enable, wb_valid);
      checkOutput("rf_rc", rf_rc, wb_rc);
      checkOutput("rf_ry", rf_ry, wb_data);
      checkOutput("pending", dut.u_sb.pending, m_pend);

      np = m_pend;
      if (wb_valid && wb_rc != 5'd0) np[wb_rc] = 1'b0;
      if (reset) begin
        m_held = 0; m_present = 0; np = '0;
      end else if (m_held) begin
        stall = pendLive(m_ra) || pendLive(m_rb) || (m_wr && pendLive(m_rc));
        if (!stall) begin
          m_a = modelOperand(m_ra);
          m_b = modelOperand(m_rb);
          m_orc = m_rc;
          m_owr = m_wr;
          if (m_wr && m_rc != 5'd0) np[m_rc] = 1'b1;
          m_held = 0;
          m_present = 1;
        end
      end else if (m_present) begin
        if (out_ready) m_present = 0;
      end else if (in_valid) begin
        m_ra = in_ra; m_rb = in_rb; m_rc = in_rc; m_wr = in_wr;
        m_held = 1;
      end
      m_pend = np;
    end
  end

  task automatic applyStimulus(input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] rc, input logic wr);
    @(posedge clk); #1;
    in_valid = 1'b1; in_ra = ra; in_rb = rb; in_rc = rc; in_wr = wr;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOut(input string name);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, out_valid, 1'b1);
  endtask

  task automatic releaseOut();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic pulseWb(input logic [4:0] rc, input logic [31:0] data);
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_rc = rc; wb_data = data;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 0; in_ra = 0; in_rb = 0; in_rc = 0; in_wr = 0;
    out_ready = 0; wb_valid = 0; wb_rc = 0; wb_data = 0;
    m_held = 0; m_present = 0; m_pend = '0;
    m_ra = 0; m_rb = 0; m_rc = 0; m_wr = 0; m_a = 0; m_b = 0; m_orc = 0; m_owr = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : 32'd100 * i + 32'd7;
    rf_mem[1] = 32'd10;
    rf_mem[2] = 32'd4;

    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_out_a", out_a, 32'd0);
    checkOutput("reset_out_rc", out_rc, 5'd0);

    // No-hazard flow, then backpressure
    applyStimulus(5'd1, 5'd2, 5'd3, 1'b1);
    waitOut("nohaz_timeout");
    checkOutput("nohaz_out_a", out_a, 32'd10);
    checkOutput("nohaz_out_b", out_b, 32'd4);
    checkOutput("nohaz_out_rc", out_rc, 5'd3);
    checkOutput("nohaz_pending3", dut.u_sb.pending[3], 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", out_valid, 1'b1);
      checkOutput("bp_out_a", out_a, 32'd10);
      checkOutput("bp_out_b", out_b, 32'd4);
      checkOutput("bp_in_ready", in_ready, 1'b0);
    end
    releaseOut();
    @(negedge clk);
    checkOutput("bp_idle_after_ready", in_ready, 1'b1);

    // RAW stall on x3, resolved by a same-cycle writeback
    applyStimulus(5'd3, 5'd2, 5'd7, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("raw_stall", out_valid, 1'b0);
    end
    pulseWb(5'd3, 32'd14);
    @(negedge clk);
    checkOutput("raw_out_valid", out_valid, 1'b1);
    checkOutput("raw_out_a", out_a, 32'd14);
    checkOutput("raw_pending3", dut.u_sb.pending[3], 1'b0);
    releaseOut();

    // Zero register never becomes pending
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1);
    waitOut("zero_timeout");
    checkOutput("zero_out_a", out_a, 32'd0);
    checkOutput("zero_out_b", out_b, 32'd0);
    checkOutput("zero_pending", dut.u_sb.pending, 32'd0);
    releaseOut();
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_rc = 5'd0; wb_data = 32'd99;
    @(negedge clk);
    checkOutput("zero_wb_le", rf_load_enable, 1'b1);
    checkOutput("zero_wb_ry", rf_ry, 32'd99);
    @(posedge clk); #1 wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("zero_wb_pending", dut.u_sb.pending, 32'd0);

    // WAW stall on x5; set wins over the same-edge clear
    applyStimulus(5'd1, 5'd2, 5'd5, 1'b1);
    waitOut("waw_setup_timeout");
    releaseOut();
    applyStimulus(5'd0, 5'd0, 5'd5, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("waw_stall", out_valid, 1'b0);
    end
    pulseWb(5'd5, 32'd55);
    @(negedge clk);
    checkOutput("waw_out_valid", out_valid, 1'b1);
    checkOutput("waw_out_rc", out_rc, 5'd5);
    checkOutput("waw_pending5", dut.u_sb.pending[5], 1'b1);
    releaseOut();

    // Writeback to a register that is not pending
    pulseWb(5'd9, 32'd90);
    @(negedge clk);
    checkOutput("wb_nonpending", dut.u_sb.pending, 32'h0000_0020);

    // Reset while stalled in HOLD; writeback passes through during reset
    applyStimulus(5'd5, 5'd0, 5'd6, 1'b1);
    @(negedge clk);
    checkOutput("rsthold_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; wb_valid = 1'b1; wb_rc = 5'd4; wb_data = 32'd44;
    @(negedge clk);
    checkOutput("rst_wb_le", rf_load_enable, 1'b1);
    checkOutput("rst_wb_ry", rf_ry, 32'd44);
    @(posedge clk); #1;
    reset = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("rsthold_in_ready_after", in_ready, 1'b1);
    checkOutput("rsthold_pending", dut.u_sb.pending, 32'd0);

    // Reset while presenting in OUT
    applyStimulus(5'd1, 5'd2, 5'd8, 1'b1);
    waitOut("rstout_timeout");
    checkOutput("rstout_pending8", dut.u_sb.pending, 32'h0000_0100);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstout_out_valid", out_valid, 1'b0);
    checkOutput("rstout_out_a", out_a, 32'd0);
    checkOutput("rstout_pending", dut.u_sb.pending, 32'd0);

    // Operand b forwarded from a writeback in the latch cycle
    applyStimulus(5'd4, 5'd6, 5'd0, 1'b0);
    wb_valid = 1'b1; wb_rc = 5'd6; wb_data = 32'd66;
    @(posedge clk); #1 wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("fwd_out_valid", out_valid, 1'b1);
    checkOutput("fwd_out_a", out_a, 32'd44);
    checkOutput("fwd_out_b", out_b, 32'd66);
    releaseOut();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; ports clk and reset.
REQ-002 SHALL expose ports:
- clk, in, 1, clock
- reset, in, 1, synchronous active-high reset
- in_valid, in, 1, upstream instruction valid
- in_ready, out, 1, block can accept instruction
- in_ra, in_rb, in, 5 each, source register numbers
- in_rc, in, 5, destination register number
- in_wr, in, 1, instruction writes in_rc
- rf_ra, rf_rb, out, 5 each, register-file read addresses
- rf_rd1, rf_rd2, in, 32 each, register-file asynchronous read data
- out_valid, in/out: out, 1, operands valid downstream
- out_ready, in, 1, downstream accepts
- out_a, out_b, out, 32 each, resolved operands
- out_rc, out, 5, destination passed downstream
- out_wr, out, 1, write flag passed downstream
- wb_valid, in, 1, writeback request
- wb_rc, in, 5, writeback destination
- wb_data, in, 32, writeback data
- rf_load_enable, out, 1, register-file write enable
- rf_rc, out, 5, register-file write address
- rf_ry, out, 32, register-file write data

Function
REQ-003 SHALL implement FSM states IDLE, HOLD, OUT.
REQ-004 IDLE: in_ready=1; on in_valid, capture in_ra/in_rb/in_rc/in_wr and move to HOLD.
REQ-005 in_ready SHALL be 1 only in IDLE.
REQ-006 HOLD: rf_ra/rf_rb SHALL equal the held sources; in all other states they SHALL equal 0.
REQ-007 Hazard: a held source s≠0 is pending in the scoreboard and not matched by (wb_valid && wb_rc==s) this cycle; or held in_wr=1, rc≠0, and rc pending and not cleared this cycle.
REQ-008 HOLD with no hazard: latch out_a/out_b, out_rc, and out_wr; set the scoreboard bit for rc if wr=1 and rc≠0; move to OUT.
REQ-009 HOLD with a hazard: remain in HOLD.
REQ-010 Operand resolution: 0 if s==0; else wb_data if wb_valid && wb_rc==s; else rf_rd1 (for ra) or rf_rd2 (for rb).
REQ-011 OUT: out_valid=1, outputs held stable; on out_ready move to IDLE.
REQ-012 Minimum latency: capture at edge N, latch at N+1, out_valid visible after N+1; no back-to-back acceptance (one instruction in flight per block).
REQ-013 Writeback pass-through SHALL be combinational: rf_load_enable=wb_valid, rf_rc=wb_rc, rf_ry=wb_data; it is independent of FSM state.
REQ-014 The scoreboard bit for wb_rc SHALL clear at the edge where wb_valid=1.
REQ-015 Same-edge set and clear on the same register: set SHALL win.
REQ-016 Register 0 SHALL never be pending; wb_rc=0 SHALL change no scoreboard bit.
REQ-017 Writeback to a non-pending register SHALL be accepted and leave the scoreboard unchanged.

Reset
REQ-018 On reset: state IDLE, scoreboard all 0, held fields 0, out_valid=0, out_a/out_b/out_rc/out_wr=0.
REQ-019 Reset mid-operation SHALL drop any held or output instruction without handshake.
REQ-020 During reset, the writeback pass-through SHALL remain combinational per REQ-013.

Structure
REQ-021 The shared package SHALL hold NUM_REGS=32, REG_ADDR_W=5, DATA_W=32, and the FSM state enum.
REQ-022 The scoreboard SHALL be a sub-module reg_scoreboard: 32 pending bits, set/clear ports, and two source-query plus one destination-query outputs with same-cycle clear masking.

Verification
REQ-023 No-hazard flow: rf x1=10, x2=4; issue ra=1, rb=2, rc=3, wr=1 -> out_valid two edges later, out_a=10, out_b=4, out_rc=3, pending[3]=1.
REQ-024 RAW stall: with pending[3]=1, issue ra=3 -> stays in HOLD; assert wb_valid, wb_rc=3, wb_data=14 -> same-cycle latch, out_a=14, pending[3]=0.
REQ-025 Zero register: issue ra=0, rb=0, rc=0, wr=1 -> out_a=0, out_b=0, no scoreboard bit set; wb to rc=0 -> rf_load_enable=1, scoreboard unchanged.
REQ-026 Backpressure: hold out_ready=0 for 5 cycles -> out_valid, out_a, and out_b stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-027 WAW stall: pending[5]=1, issue rc=5, wr=1 -> stalls until wb_rc=5, then pending[5]=1 again (set wins).
REQ-028 Reset in HOLD and in OUT -> next cycle IDLE, out_valid=0, scoreboard all zero.
